// File: rtl/demux_scan_scheduler.sv
// Round-robin scheduler driving the S/E lines of a 1:16 demux.
// Each grant is GUARD blanking cycles (E=0) followed by a DWELL-cycle slot (E=1).
module demux_scan_scheduler #(
   parameter int GUARD   = 1,
   parameter int DWELL_W = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               EN,
   input  logic [15:0]        REQ,
   input  logic [DWELL_W-1:0] DWELL,
   output logic [3:0]         S,
   output logic               E,
   output logic               BUSY,
   output logic               CH_DONE
);

   localparam int GCW = (GUARD > 1) ? $clog2(GUARD) : 1;
   localparam logic [GCW-1:0] GLOAD = GCW'((GUARD > 0) ? (GUARD - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GUARD = 2'd1,
      ST_ON    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         ptr_q, ptr_d;
   logic [3:0]         s_q, s_d;
   logic               e_q, e_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [GCW-1:0]     gcnt_q, gcnt_d;
   logic [DWELL_W-1:0] dcnt_q, dcnt_d;

   logic [4:0]         pick;
   logic               grant_vld;
   logic [3:0]         grant_ch;
   logic [DWELL_W-1:0] dwell_m1;
   logic               do_grant;
   logic               enter_on;

   // Search starts just after the last grant; the last-granted channel is checked last.
   function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr);
      logic       found;
      logic [3:0] idx;
      logic [3:0] ch;
      found = 1'b0;
      ch    = 4'd0;
      for (int k = 1; k <= 16; k++) begin
         idx = ptr + 4'(k);
         if (!found && req[idx]) begin
            found = 1'b1;
            ch    = idx;
         end else begin
            found = found;
         end
      end
      return {found, ch};
   endfunction

   assign pick      = rr_pick(REQ, ptr_q);
   assign grant_vld = pick[4];
   assign grant_ch  = pick[3:0];
   // Dwell counter holds remaining cycles minus one, so DWELL=0 behaves like DWELL=1.
   assign dwell_m1  = (DWELL == '0) ? '0 : (DWELL - DWELL_W'(1));

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      s_d      = s_q;
      gcnt_d   = gcnt_q;
      dcnt_d   = dcnt_q;
      do_grant = 1'b0;
      enter_on = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (EN && grant_vld) begin
               do_grant = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GUARD: begin
            if (!EN) begin
               state_d = ST_IDLE;
            end else if (gcnt_q == '0) begin
               enter_on = 1'b1;
            end else begin
               gcnt_d = gcnt_q - GCW'(1);
            end
         end
         ST_ON: begin
            if (!EN) begin
               state_d = ST_IDLE;
            end else if (dcnt_q == '0) begin
               if (grant_vld) begin
                  do_grant = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               dcnt_d = dcnt_q - DWELL_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (do_grant) begin
         ptr_d = grant_ch;
         s_d   = grant_ch;
         if (GUARD > 0) begin
            state_d = ST_GUARD;
            gcnt_d  = GLOAD;
         end else begin
            enter_on = 1'b1;
         end
      end else begin
         ptr_d = ptr_d;
      end

      if (enter_on) begin
         state_d = ST_ON;
         dcnt_d  = dwell_m1;
      end else begin
         dcnt_d = dcnt_d;
      end

      // Outputs are precomputed from next state so every port is a flop.
      e_d    = (state_d == ST_ON);
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_ON) && (dcnt_d == '0);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         ptr_q   <= 4'd15;
         s_q     <= 4'd0;
         e_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         gcnt_q  <= '0;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         s_q     <= s_d;
         e_q     <= e_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         gcnt_q  <= gcnt_d;
         dcnt_q  <= dcnt_d;
      end
   end

   assign S       = s_q;
   assign E       = e_q;
   assign BUSY    = busy_q;
   assign CH_DONE = done_q;

endmodule

// File: tb/tb_demux_scan_scheduler.sv
// Directed bench for demux_scan_scheduler: one instance with GUARD=1, one with GUARD=0.
module tb_demux_scan_scheduler;

   logic        CLK = 1'b0;
   logic        RST;
   logic        EN;
   logic [15:0] REQ;
   logic [7:0]  DWELL;

   logic [3:0]  s1, s0;
   logic        e1, e0, b1, b0, d1, d0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   demux_scan_scheduler #(.GUARD(1), .DWELL_W(8)) u_g1 (
      .CLK(CLK), .RST(RST), .EN(EN), .REQ(REQ), .DWELL(DWELL),
      .S(s1), .E(e1), .BUSY(b1), .CH_DONE(d1)
   );

   demux_scan_scheduler #(.GUARD(0), .DWELL_W(8)) u_g0 (
      .CLK(CLK), .RST(RST), .EN(EN), .REQ(REQ), .DWELL(DWELL),
      .S(s0), .E(e0), .BUSY(b0), .CH_DONE(d0)
   );

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      EN  = 1'b0;
      tick();
      RST = 1'b0;
   endtask

   initial begin
      RST = 1'b1; EN = 1'b1; REQ = 16'hFFFF; DWELL = 8'd3;
      #1;

      // Reset held two cycles with EN and all requests active
      tick(); tick();
      check_eq("rst_S", {12'd0, s1}, 16'd0);
      check_eq("rst_E", {15'd0, e1}, 16'd0);
      check_eq("rst_BUSY", {15'd0, b1}, 16'd0);
      check_eq("rst_DONE", {15'd0, d1}, 16'd0);
      RST = 1'b0;
      tick();
      check_eq("first_S", {12'd0, s1}, 16'd0);
      check_eq("first_BUSY", {15'd0, b1}, 16'd1);
      check_eq("first_E", {15'd0, e1}, 16'd0);
      tick(); tick(); tick();
      check_eq("first_done", {15'd0, d1}, 16'd1);
      tick();
      check_eq("second_S", {12'd0, s1}, 16'd1);
      check_eq("second_E", {15'd0, e1}, 16'd0);

      // Single requester re-granted forever: E = 0,1,1,1
      do_reset();
      REQ = 16'h0010; DWELL = 8'd3; EN = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check_eq("single_S", {12'd0, s1}, 16'd4);
         check_eq("single_E", {15'd0, e1}, (k % 4 == 0) ? 16'd0 : 16'd1);
         check_eq("single_DONE", {15'd0, d1}, (k % 4 == 3) ? 16'd1 : 16'd0);
         check_eq("single_BUSY", {15'd0, b1}, 16'd1);
      end

      // Two requesters at the ends of the ring
      do_reset();
      REQ = 16'h8001; DWELL = 8'd2; EN = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         check_eq("wrap2_S", {12'd0, s1}, ((k / 3) % 2 == 0) ? 16'd0 : 16'd15);
         check_eq("wrap2_E", {15'd0, e1}, (k % 3 == 0) ? 16'd0 : 16'd1);
      end

      // Full ring, each S held GUARD+DWELL = 3 cycles
      do_reset();
      REQ = 16'hFFFF; DWELL = 8'd2; EN = 1'b1;
      for (int k = 0; k < 51; k++) begin
         tick();
         check_eq("ring_S", {12'd0, s1}, 16'((k / 3) % 16));
      end

      // Abort on the second E=1 cycle of a 5-cycle slot
      do_reset();
      REQ = 16'h0004; DWELL = 8'd5; EN = 1'b1;
      tick();
      check_eq("abort_guard_S", {12'd0, s1}, 16'd2);
      tick();
      check_eq("abort_on1_E", {15'd0, e1}, 16'd1);
      tick();
      check_eq("abort_on2_E", {15'd0, e1}, 16'd1);
      check_eq("abort_on2_DONE", {15'd0, d1}, 16'd0);
      EN = 1'b0;
      tick();
      check_eq("abort_E", {15'd0, e1}, 16'd0);
      check_eq("abort_BUSY", {15'd0, b1}, 16'd0);
      check_eq("abort_DONE", {15'd0, d1}, 16'd0);
      check_eq("abort_S_hold", {12'd0, s1}, 16'd2);
      EN = 1'b1; REQ = 16'hFFFF;
      tick();
      check_eq("abort_regrant_S", {12'd0, s1}, 16'd3);
      check_eq("abort_regrant_BUSY", {15'd0, b1}, 16'd1);

      // No blanking, DWELL=0: continuous E, alternating S
      do_reset();
      REQ = 16'h0003; DWELL = 8'd0; EN = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check_eq("g0_S", {12'd0, s0}, 16'(k % 2));
         check_eq("g0_E", {15'd0, e0}, 16'd1);
         check_eq("g0_DONE", {15'd0, d0}, 16'd1);
         check_eq("g0_BUSY", {15'd0, b0}, 16'd1);
      end

      // Reset while channel 7 is on
      do_reset();
      REQ = 16'h0080; DWELL = 8'd4; EN = 1'b1;
      tick(); tick();
      check_eq("rston_S", {12'd0, s1}, 16'd7);
      check_eq("rston_E", {15'd0, e1}, 16'd1);
      RST = 1'b1; REQ = 16'h0028;
      tick();
      check_eq("rston_rst_S", {12'd0, s1}, 16'd0);
      check_eq("rston_rst_E", {15'd0, e1}, 16'd0);
      check_eq("rston_rst_BUSY", {15'd0, b1}, 16'd0);
      RST = 1'b0;
      tick();
      check_eq("rston_grant_S", {12'd0, s1}, 16'd3);
      check_eq("rston_grant_BUSY", {15'd0, b1}, 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
